// File: rtl/disp_pkg.sv
// Shared display types and constants for the seven-segment observation path.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        PAGE_LO = 1'b0,
        PAGE_HI = 1'b1
    } page_e;

    function automatic logic [15:0] half_sel(input logic [31:0] word, input page_e pg);
        return (pg == PAGE_HI) ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/mem_write_display.sv
// Captures data-memory writes to a watched address and pages the captured
// word across four seven-segment digits, low half then high half.
module mem_write_display
    import disp_pkg::*;
#(
    parameter int unsigned PAGE_CYCLES = 25_000_000,
    parameter logic [31:0] WATCH_ADDR  = 32'h54,
    parameter bit          WATCH_ALL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        hold,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        page,
    output logic        cap_valid,
    output logic [7:0]  hits
);

    localparam int unsigned CW = $clog2(PAGE_CYCLES);
    localparam logic [CW-1:0] TC = CW'(PAGE_CYCLES - 1);

    logic [31:0]   cap_q, cap_d;
    logic          cap_valid_q, cap_valid_d;
    page_e         page_q, page_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    hits_q, hits_d;
    seg_t          hex_q [4];
    seg_t          hex_d [4];
    seg_t          seg   [4];
    logic [15:0]   half;
    logic          match;

    assign match = memwrite && (WATCH_ALL || (dataadr == WATCH_ADDR)) && !hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
            page_q      <= PAGE_LO;
            cnt_q       <= '0;
            hits_q      <= '0;
            for (int unsigned i = 0; i < 4; i++) hex_q[i] <= SEG_DASH;
        end else begin
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            page_q      <= page_d;
            cnt_q       <= cnt_d;
            hits_q      <= hits_d;
            for (int unsigned i = 0; i < 4; i++) hex_q[i] <= hex_d[i];
        end
    end

    // A capture restarts the page sequence and takes priority over a terminal-count toggle.
    always_comb begin
        cap_d       = cap_q;
        cap_valid_d = cap_valid_q;
        page_d      = page_q;
        cnt_d       = cnt_q;
        hits_d      = hits_q;
        if (match) begin
            cap_d       = writedata;
            cap_valid_d = 1'b1;
            hits_d      = (hits_q == '1) ? hits_q : hits_q + 8'd1;
            page_d      = PAGE_LO;
            cnt_d       = '0;
        end else if (cap_valid_q && !hold) begin
            if (cnt_q == TC) begin
                cnt_d  = '0;
                page_d = (page_q == PAGE_LO) ? PAGE_HI : PAGE_LO;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign half = half_sel(cap_q, page_q);

    for (genvar g = 0; g < 4; g++) begin : g_digit
        hex_to_7seg u_dec (
            .nibble_i (half[4*g +: 4]),
            .seg_o    (seg[g])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            hex_d[i] = cap_valid_q ? seg[i] : SEG_DASH;
        end
    end

    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];
    assign page      = page_q;
    assign cap_valid = cap_valid_q;
    assign hits      = hits_q;

endmodule

// File: tb/tb_mem_write_display.sv
// Directed self-checking bench for mem_write_display with a 4-cycle page.
module tb_mem_write_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        hold = 1'b0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic        page, cap_valid;
    logic [7:0]  hits;

    int n_pass  = 0;
    int n_total = 0;

    mem_write_display #(
        .PAGE_CYCLES (4),
        .WATCH_ADDR  (32'h54),
        .WATCH_ALL   (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .hold      (hold),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .page      (page),
        .cap_valid (cap_valid),
        .hits      (hits)
    );

    always #5 clk = ~clk;

    localparam logic [27:0] DASHES  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] D_0007  = {7'h40, 7'h40, 7'h40, 7'h78};
    localparam logic [27:0] D_0000  = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] D_ABCD  = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] D_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] D_BEEF  = {7'h03, 7'h06, 7'h06, 7'h0E};
    localparam logic [27:0] D_4321  = {7'h19, 7'h30, 7'h24, 7'h79};

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] hexw();
        return {4'h0, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic write(input logic [31:0] adr, input logic [31:0] dat);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = dat;
        step();
        memwrite  = 1'b0;
    endtask

    initial begin
        // 1. Reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("reset_hex", hexw(), {4'h0, DASHES});
        chk("reset_valid", {31'b0, cap_valid}, 32'd0);
        chk("reset_hits", {24'b0, hits}, 32'd0);
        chk("reset_page", {31'b0, page}, 32'd0);
        step(2);
        reset = 1'b0;
        step();
        chk("idle_hex", hexw(), {4'h0, DASHES});

        // 2. Capture and ignore
        write(32'h54, 32'h0000_0007);
        chk("cap1_valid", {31'b0, cap_valid}, 32'd1);
        chk("cap1_hits", {24'b0, hits}, 32'd1);
        chk("cap1_latency", hexw(), {4'h0, DASHES});
        step();
        chk("cap1_hex", hexw(), {4'h0, D_0007});
        write(32'h50, 32'hFFFF_FFFF);
        step();
        chk("ignore_hex", hexw(), {4'h0, D_0007});
        chk("ignore_hits", {24'b0, hits}, 32'd1);

        // 3. Paging
        write(32'h54, 32'h1234_ABCD);
        chk("cap2_hits", {24'b0, hits}, 32'd2);
        chk("cap2_page", {31'b0, page}, 32'd0);
        step();
        chk("cap2_hex", hexw(), {4'h0, D_ABCD});
        step(3);
        chk("page_hi", {31'b0, page}, 32'd1);
        step();
        chk("page_hi_hex", hexw(), {4'h0, D_1234});
        step(3);
        chk("page_lo", {31'b0, page}, 32'd0);
        step();
        chk("page_lo_hex", hexw(), {4'h0, D_ABCD});

        // 4. Capture on the terminal-count cycle
        step(2);
        chk("pre_tc_page", {31'b0, page}, 32'd0);
        write(32'h54, 32'h0000_BEEF);
        chk("tc_cap_page", {31'b0, page}, 32'd0);
        chk("tc_cap_hits", {24'b0, hits}, 32'd3);
        step();
        chk("tc_cap_hex", hexw(), {4'h0, D_BEEF});
        step(2);
        chk("tc_full_page", {31'b0, page}, 32'd0);
        chk("tc_full_hex", hexw(), {4'h0, D_BEEF});
        step();
        chk("tc_toggle", {31'b0, page}, 32'd1);
        step();
        chk("tc_hi_hex", hexw(), {4'h0, D_0000});

        // 5. Hold: counter frozen at 1 with page high
        hold = 1'b1;
        write(32'h54, 32'h5555_5555);
        step(10);
        chk("hold_page", {31'b0, page}, 32'd1);
        chk("hold_hits", {24'b0, hits}, 32'd3);
        chk("hold_hex", hexw(), {4'h0, D_0000});
        hold = 1'b0;
        step(2);
        chk("resume_page_hi", {31'b0, page}, 32'd1);
        step();
        chk("resume_page_lo", {31'b0, page}, 32'd0);
        step();
        chk("resume_hex", hexw(), {4'h0, D_BEEF});

        // 6. Saturation, then reset mid-page
        memwrite  = 1'b1;
        dataadr   = 32'h54;
        writedata = 32'h8765_4321;
        step(250);
        chk("hits_253", {24'b0, hits}, 32'd253);
        step(50);
        memwrite = 1'b0;
        chk("hits_sat", {24'b0, hits}, 32'hFF);
        step(4);
        chk("sat_page_hi", {31'b0, page}, 32'd1);
        chk("sat_hex", hexw(), {4'h0, D_4321});
        reset = 1'b1;
        #1;
        chk("midreset_hex", hexw(), {4'h0, DASHES});
        chk("midreset_hits", {24'b0, hits}, 32'd0);
        chk("midreset_page", {31'b0, page}, 32'd0);
        chk("midreset_valid", {31'b0, cap_valid}, 32'd0);
        step(2);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
